roba_mult_pipe: RTL

- Pipelined, parametrised successor to the combinational rounding-based approximate (RoBA) multiplier.
- Adds signed/unsigned operand support and a runtime exact/approximate mode.
- Adds a 3-stage registered datapath with valid/ready flow control and an accepted-operation counter.
- Sits between the operand feeders and the PE accumulators in the approximate systolic array.

---
 rtl/roba_mult_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/roba_mult_pipe.sv
// Pipelined rounding-based approximate (RoBA) multiplier with signed/unsigned operands,
// runtime exact/approximate mode, valid/ready flow control and an accepted-operation counter.
module roba_mult_pipe #(
    parameter  int A_BW   = 8,
    parameter  int B_BW   = 8,
    parameter  int CNT_BW = 16,
    localparam int R_BW   = A_BW + B_BW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [A_BW-1:0]   in_a,
    input  logic [B_BW-1:0]   in_b,
    input  logic              in_signed,
    input  logic              in_exact,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [R_BW-1:0]   out_r,
    output logic [CNT_BW-1:0] op_count
);

    localparam int MW = (A_BW > B_BW) ? A_BW : B_BW;
    localparam int EW = $clog2(A_BW + B_BW + 2);

    // Exponent of the nearest power of two; the bit just below the leading one decides
    // whether to round up, so ties go up. Callers handle the zero case separately.
    function automatic logic [EW-1:0] round_exp(input logic [MW-1:0] x);
        logic [MW:0] below;
        below     = {x, 1'b0};
        round_exp = '0;
        for (int i = 0; i < MW; i++) begin
            if (x[i]) begin
                round_exp = below[i] ? EW'(i + 1) : EW'(i);
            end
        end
    endfunction

    logic              stall;
    logic              advance;
    logic              take;

    logic              v1;
    logic              s1;
    logic              ex1;
    logic [A_BW-1:0]   ma1;
    logic [B_BW-1:0]   mb1;

    logic              v2;
    logic              s2;
    logic [R_BW-1:0]   t1_2;
    logic [R_BW-1:0]   t2_2;
    logic [R_BW-1:0]   t3_2;

    logic [A_BW-1:0]   mag_a;
    logic [B_BW-1:0]   mag_b;
    logic              sign_in;

    logic [EW-1:0]     exp_a;
    logic [EW-1:0]     exp_b;
    logic              zero_a;
    logic              zero_b;
    logic [R_BW-1:0]   term_arb;
    logic [R_BW-1:0]   term_bra;
    logic [R_BW-1:0]   term_arbr;
    logic [R_BW-1:0]   prod_exact;
    logic [R_BW-1:0]   p;

    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;
    assign take     = in_valid & in_ready;

    // The negated minimum signed value wraps back onto itself, which read as unsigned is 2^(W-1).
    assign mag_a   = (in_signed & in_a[A_BW-1]) ? -in_a : in_a;
    assign mag_b   = (in_signed & in_b[B_BW-1]) ? -in_b : in_b;
    assign sign_in = in_signed & (in_a[A_BW-1] ^ in_b[B_BW-1]);

    assign exp_a  = round_exp(MW'(ma1));
    assign exp_b  = round_exp(MW'(mb1));
    assign zero_a = (ma1 == '0);
    assign zero_b = (mb1 == '0);

    // Rounded operands are powers of two, so every partial product is a shift.
    assign term_arb   = zero_a ? '0 : (R_BW'(mb1) << exp_a);
    assign term_bra   = zero_b ? '0 : (R_BW'(ma1) << exp_b);
    assign term_arbr  = (zero_a | zero_b) ? '0 : (R_BW'(1) << (exp_a + exp_b));
    assign prod_exact = R_BW'(ma1) * R_BW'(mb1);

    // Exact mode reuses the first term slot so the combine stage needs no mode mux.
    assign p = t1_2 + t2_2 - t3_2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            s1        <= 1'b0;
            ex1       <= 1'b0;
            ma1       <= '0;
            mb1       <= '0;
            v2        <= 1'b0;
            s2        <= 1'b0;
            t1_2      <= '0;
            t2_2      <= '0;
            t3_2      <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            op_count  <= '0;
        end else begin
            if (take) begin
                op_count <= op_count + CNT_BW'(1);
            end
            if (advance) begin
                v1        <= in_valid;
                s1        <= sign_in;
                ex1       <= in_exact;
                ma1       <= mag_a;
                mb1       <= mag_b;

                v2        <= v1;
                s2        <= s1;
                t1_2      <= ex1 ? prod_exact : term_arb;
                t2_2      <= ex1 ? '0 : term_bra;
                t3_2      <= ex1 ? '0 : term_arbr;

                out_valid <= v2;
                out_r     <= s2 ? -p : p;
            end
        end
    end

endmodule
